reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_sb_pkg.sv | 15 +
 rtl/reg_file_sb_score.sv | 65 ++++++
 rtl/reg_file_sb.sv | 81 ++++++++
 tb/tb_reg_file_sb.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_sb_pkg.sv
// Shared CPU package: default datapath widths, the hardwired zero-register
// index and the helper used to locate a read port inside a packed bus.
package reg_file_sb_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned NRD_DEF    = 2;
  localparam int unsigned ZERO_REG   = 0;

  // Bit offset of read port p in a bus packed at w bits per port.
  function automatic int unsigned port_lsb(input int unsigned p, input int unsigned w);
    return p * w;
  endfunction

endpackage

// File: rtl/reg_file_sb_score.sv
// Scoreboard for reg_file_sb: one pending bit per register plus a running
// count of set bits. Issue marks a register pending, a write clears it, and
// flush drops every mark. Register 0 is never marked.
module reg_file_sb_score
  import reg_file_sb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  localparam int unsigned DEPTH = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic              flush,
  output logic [DEPTH-1:0]  busy,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  logic             set_hit;
  logic             clr_hit;
  logic             inc;
  logic             dec;
  logic [DEPTH-1:0] busy_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  // Next pending vector and count; set beats clear on the same register.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    busy_nxt = busy;
    cnt_nxt  = busy_cnt;
    set_hit  = iss_valid && (iss_addr != ADDR_W'(ZERO_REG)) && !flush;
    clr_hit  = we && !(set_hit && (iss_addr == wr_addr));
    inc      = set_hit && !busy[iss_addr];
    dec      = clr_hit && busy[wr_addr];
    if (flush) begin
      busy_nxt = '0;
      cnt_nxt  = '0;
    end else begin
      if (clr_hit) busy_nxt[wr_addr]  = 1'b0;
      if (set_hit) busy_nxt[iss_addr] = 1'b1;
      // Only genuine transitions move the count, so redundant sets/clears
      // cannot push it past the number of registers or below zero.
      cnt_nxt = busy_cnt + CNT_W'(inc) - CNT_W'(dec);
    end
  end

  // Pending bits and count register, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge Reset) begin
    // NOTE: state registers use non-blocking assignment so every flop
    // samples the pre-edge values regardless of statement order.
    if (!Reset) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with scoreboard: 2**ADDR_W registers of DATA_W bits, NRD
// combinational read ports, one write port, and a pending-write scoreboard
// (reg_file_sb_score) that flags registers still awaiting their producer.
// Register 0 reads as zero and is never pending.
// Optional feature: define REG_FILE_SB_BYPASS_EN to forward a same-cycle
// write to matching read ports (data taken from wr_data, busy forced low).
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned NRD    = NRD_DEF
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  iss_valid,
  input  logic [ADDR_W-1:0]     iss_addr,
  input  logic                  flush,
  output logic [ADDR_W:0]       busy_cnt
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;

  reg_file_sb_score #(
    .ADDR_W (ADDR_W)
  ) u_score (
    .clk       (clk),
    .Reset     (Reset),
    .we        (we),
    .wr_addr   (wr_addr),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .flush     (flush),
    .busy      (busy),
    .busy_cnt  (busy_cnt)
  );

  // Storage: writes to register 0 are dropped; whole array clears on reset.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      // NOTE: the storage array is reset because the architecture requires
      // every register to read zero after reset; this forces flops rather
      // than RAM macros, which is acceptable at this size.
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (we && (wr_addr != ADDR_W'(ZERO_REG))) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Read muxes: stored value and pending flag per port, optional forwarding.
  always_comb begin : read_ports
    logic [ADDR_W-1:0] ra;
    ra      = '0;
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned p = 0; p < NRD; p++) begin
      ra = rd_addr[port_lsb(p, ADDR_W) +: ADDR_W];
      if (ra != ADDR_W'(ZERO_REG)) begin
        rd_data[port_lsb(p, DATA_W) +: DATA_W] = regs[ra];
        rd_busy[p]                             = busy[ra];
`ifdef REG_FILE_SB_BYPASS_EN
        // Forwarding is suppressed during reset so outputs stay at zero.
        if (Reset && we && (wr_addr == ra)) begin
          rd_data[port_lsb(p, DATA_W) +: DATA_W] = wr_data;
          rd_busy[p]                             = 1'b0;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb (NRD=4, default widths). Directed
// scenarios plus randomized traffic compared against a behavioural model
// built from plain arrays. Honours REG_FILE_SB_BYPASS_EN if defined.
module tb_reg_file_sb;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NRD   = 4;
  localparam int DEPTH = 32;

`ifdef REG_FILE_SB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              Reset;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              we;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              iss_valid;
  logic [AW-1:0]     iss_addr;
  logic              flush;
  logic [AW:0]       busy_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: register contents and pending flags.
  logic [DW-1:0] m_reg  [DEPTH];
  bit            m_busy [DEPTH];

  reg_file_sb #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .NRD    (NRD)
  ) dut (
    .clk       (clk),
    .Reset     (Reset),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .we        (we),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .flush     (flush),
    .busy_cnt  (busy_cnt)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endfunction

  // Architectural effect of one rising edge with the current inputs.
  function automatic void model_clock();
    if (we && wr_addr != 0) m_reg[wr_addr] = wr_data;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
    end else begin
      if (we) m_busy[wr_addr] = 1'b0;
      if (iss_valid && iss_addr != 0) m_busy[iss_addr] = 1'b1;
    end
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic logic [DW-1:0] model_data(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (BYPASS && we && wr_addr == a) return wr_data;
    return m_reg[a];
  endfunction

  function automatic logic model_busy(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
    if (BYPASS && we && wr_addr == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  task automatic idle();
    we = 1'b0; wr_addr = '0; wr_data = '0;
    iss_valid = 1'b0; iss_addr = '0; flush = 1'b0;
  endtask

  // Advance one clock; the model sees the inputs held across the edge.
  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
    idle();
  endtask

  // Mid-cycle reset pulse, away from any clock edge.
  task automatic pulse_reset();
    @(negedge clk);
    #2;
    Reset = 1'b0;
    #1;
    Reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_rd(0, 5'd5);
    #2;
    n_cmp++;
    if (rd_data[0 +: DW] !== 32'h0) begin
      n_err++; $display("FAIL reset_state_data: got %h expected 00000000", rd_data[0 +: DW]);
    end
    n_cmp++;
    if (busy_cnt !== 6'd0) begin
      n_err++; $display("FAIL reset_state_cnt: got %0d expected 0", busy_cnt);
    end
    we = 1'b1; wr_addr = 5'd5; wr_data = 32'h1234;
    iss_valid = 1'b1; iss_addr = 5'd6;
    tick();
    #2;
    n_cmp++;
    if (rd_data[0 +: DW] !== 32'h1234) begin
      n_err++; $display("FAIL reset_prewrite: got %h expected 00001234", rd_data[0 +: DW]);
    end
    @(negedge clk);
    #2;
    Reset = 1'b0;
    #1;
    n_cmp++;
    if (rd_data[0 +: DW] !== 32'h0) begin
      n_err++; $display("FAIL reset_async_data: got %h expected 00000000", rd_data[0 +: DW]);
    end
    n_cmp++;
    if (busy_cnt !== 6'd0) begin
      n_err++; $display("FAIL reset_async_cnt: got %0d expected 0", busy_cnt);
    end
    n_cmp++;
    if (rd_busy !== 4'b0) begin
      n_err++; $display("FAIL reset_async_busy: got %b expected 0000", rd_busy);
    end
    Reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_write_read();
    pulse_reset();
    set_rd(0, 5'd3);
    we = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEADBEEF;
    tick();
    #2;
    n_cmp++;
    if (rd_data[0 +: DW] !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL write_read_3: got %h expected deadbeef", rd_data[0 +: DW]);
    end
    set_rd(0, 5'd0);
    we = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
    iss_valid = 1'b1; iss_addr = 5'd0;
    tick();
    #2;
    n_cmp++;
    if (rd_data[0 +: DW] !== 32'h0 || rd_busy[0] !== 1'b0 || busy_cnt !== 6'd0) begin
      n_err++; $display("FAIL write_reg0: data %h busy %b cnt %0d expected 0/0/0",
                        rd_data[0 +: DW], rd_busy[0], busy_cnt);
    end
  endtask

  task automatic test_scoreboard();
    pulse_reset();
    iss_valid = 1'b1; iss_addr = 5'd7; tick();
    iss_valid = 1'b1; iss_addr = 5'd9; tick();
    set_rd(0, 5'd7);
    #2;
    n_cmp++;
    if (busy_cnt !== 6'd2 || rd_busy[0] !== 1'b1) begin
      n_err++; $display("FAIL sb_two_issued: cnt %0d busy %b expected 2/1", busy_cnt, rd_busy[0]);
    end
    we = 1'b1; wr_addr = 5'd7; wr_data = 32'h77; tick();
    #2;
    n_cmp++;
    if (busy_cnt !== 6'd1 || rd_busy[0] !== 1'b0) begin
      n_err++; $display("FAIL sb_write_clears: cnt %0d busy %b expected 1/0", busy_cnt, rd_busy[0]);
    end
    we = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
    iss_valid = 1'b1; iss_addr = 5'd9;
    tick();
    set_rd(0, 5'd9);
    #2;
    n_cmp++;
    if (busy_cnt !== 6'd1 || rd_busy[0] !== 1'b1) begin
      n_err++; $display("FAIL sb_set_wins: cnt %0d busy %b expected 1/1", busy_cnt, rd_busy[0]);
    end
    iss_valid = 1'b1; iss_addr = 5'd9; tick();
    #2;
    n_cmp++;
    if (busy_cnt !== 6'd1) begin
      n_err++; $display("FAIL sb_redundant_set: cnt %0d expected 1", busy_cnt);
    end
  endtask

  task automatic test_flush();
    pulse_reset();
    iss_valid = 1'b1; iss_addr = 5'd4; tick();
    iss_valid = 1'b1; iss_addr = 5'd6; tick();
    iss_valid = 1'b1; iss_addr = 5'd8; tick();
    #2;
    n_cmp++;
    if (busy_cnt !== 6'd3) begin
      n_err++; $display("FAIL flush_pre: cnt %0d expected 3", busy_cnt);
    end
    flush = 1'b1; iss_valid = 1'b1; iss_addr = 5'd10;
    we = 1'b1; wr_addr = 5'd11; wr_data = 32'hABCD;
    tick();
    set_rd(0, 5'd10);
    set_rd(1, 5'd11);
    #2;
    n_cmp++;
    if (busy_cnt !== 6'd0 || rd_busy[0] !== 1'b0) begin
      n_err++; $display("FAIL flush_clear: cnt %0d busy10 %b expected 0/0", busy_cnt, rd_busy[0]);
    end
    n_cmp++;
    if (rd_data[DW +: DW] !== 32'hABCD) begin
      n_err++; $display("FAIL flush_write: got %h expected 0000abcd", rd_data[DW +: DW]);
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] exp_d;
    logic          exp_b;
    pulse_reset();
    set_rd(1, 5'd12);
    iss_valid = 1'b1; iss_addr = 5'd12; tick();
    we = 1'b1; wr_addr = 5'd12; wr_data = 32'h55;
    #2;
`ifdef REG_FILE_SB_BYPASS_EN
    exp_d = 32'h55; exp_b = 1'b0;
`else
    exp_d = 32'h0;  exp_b = 1'b1;
`endif
    n_cmp++;
    if (rd_data[DW +: DW] !== exp_d || rd_busy[1] !== exp_b) begin
      n_err++; $display("FAIL bypass_same_cycle: data %h busy %b expected %h/%b",
                        rd_data[DW +: DW], rd_busy[1], exp_d, exp_b);
    end
    tick();
    #2;
    n_cmp++;
    if (rd_data[DW +: DW] !== 32'h55 || rd_busy[1] !== 1'b0) begin
      n_err++; $display("FAIL bypass_after: data %h busy %b expected 00000055/0",
                        rd_data[DW +: DW], rd_busy[1]);
    end
  endtask

  task automatic test_multiport();
    logic [DW-1:0] exp [NRD];
    pulse_reset();
    we = 1'b1; wr_addr = 5'd1;  wr_data = 32'hA; tick();
    we = 1'b1; wr_addr = 5'd31; wr_data = 32'hF; tick();
    set_rd(0, 5'd0); set_rd(1, 5'd1); set_rd(2, 5'd1); set_rd(3, 5'd31);
    exp[0] = 32'h0; exp[1] = 32'hA; exp[2] = 32'hA; exp[3] = 32'hF;
    #2;
    for (int p = 0; p < NRD; p++) begin
      n_cmp++;
      if (rd_data[p*DW +: DW] !== exp[p]) begin
        n_err++; $display("FAIL multiport_p%0d: got %h expected %h", p, rd_data[p*DW +: DW], exp[p]);
      end
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, DEPTH - 1));
    return AW'($urandom_range(0, 7));
  endfunction

  task automatic test_random();
    pulse_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int p = 0; p < NRD; p++) set_rd(p, rand_addr());
      we        = ($urandom_range(0, 2) != 0);
      wr_addr   = rand_addr();
      wr_data   = $urandom();
      iss_valid = ($urandom_range(0, 2) != 0);
      iss_addr  = rand_addr();
      flush     = ($urandom_range(0, 31) == 0);
      #2;
      for (int p = 0; p < NRD; p++) begin
        n_cmp++;
        if (rd_data[p*DW +: DW] !== model_data(rd_addr[p*AW +: AW]) ||
            rd_busy[p] !== model_busy(rd_addr[p*AW +: AW])) begin
          n_err++;
          $display("FAIL random_port%0d cyc %0d addr %0d: data %h busy %b expected %h/%b",
                   p, cyc, rd_addr[p*AW +: AW], rd_data[p*DW +: DW], rd_busy[p],
                   model_data(rd_addr[p*AW +: AW]), model_busy(rd_addr[p*AW +: AW]));
        end
      end
      n_cmp++;
      if (int'(busy_cnt) != model_count()) begin
        n_err++; $display("FAIL random_cnt cyc %0d: got %0d expected %0d", cyc, busy_cnt, model_count());
      end
      tick();
    end
  endtask

  initial begin
    Reset   = 1'b0;
    rd_addr = '0;
    idle();
    model_reset();
    #12;
    Reset = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_write_read();
    test_scoreboard();
    test_flush();
    test_bypass();
    test_multiport();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
